// File: rtl/lsu_subword_rmw.sv
// lsu_subword_rmw: byte-addressed load/store front end for the word-only Datmem.
// Sub-word stores use read-modify-write. Loads are sign- or zero-extended.
// Define LSU_STATS_EN to add the saturating LdCnt/StCnt/ErrCnt response counters.
module lsu_subword_rmw #(
  parameter int AWIDTH  = 32,
  parameter int ALENGTH = 128
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ReqVal,
  output logic              ReqRdy,
  input  logic [2:0]        ReqOp,
  input  logic [AWIDTH-1:0] ReqAddr,
  input  logic [AWIDTH-1:0] ReqDat,
  output logic              RespVal,
  input  logic              RespRdy,
  output logic [AWIDTH-1:0] RespDat,
  output logic              RespErr,
  output logic [AWIDTH-1:0] MemAddr,
  output logic              MemWE,
  output logic [AWIDTH-1:0] MemWriDat,
  input  logic [AWIDTH-1:0] MemReaDat
`ifdef LSU_STATS_EN
  ,
  output logic [15:0]       LdCnt,
  output logic [15:0]       StCnt,
  output logic [15:0]       ErrCnt
`endif
);

  typedef enum logic [2:0] {
    OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_e;

  state_e            state_q;
  op_e               op_q;
  logic [1:0]        lane_q;
  logic [AWIDTH-1:0] wdat_q;
  logic [AWIDTH-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [AWIDTH-1:0] mem_wdat_q;
  logic              resp_val_q;
  logic [AWIDTH-1:0] resp_dat_q;
  logic              resp_err_q;

  op_e               req_op;
  logic [AWIDTH-1:0] req_idx;
  logic              req_err;

  function automatic logic is_store(input op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Select the addressed lane of the read word and extend it to full width.
  function automatic logic [AWIDTH-1:0] load_ext(input op_e op, input logic [1:0] lane,
                                                 input logic [AWIDTH-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (op)
      OP_LH:   return {{(AWIDTH-16){h[15]}}, h};
      OP_LHU:  return {{(AWIDTH-16){1'b0}}, h};
      OP_LB:   return {{(AWIDTH-8){b[7]}}, b};
      OP_LBU:  return {{(AWIDTH-8){1'b0}}, b};
      default: return word;
    endcase
  endfunction

  // Overwrite only the store lanes of the read word.
  function automatic logic [AWIDTH-1:0] merge(input op_e op, input logic [1:0] lane,
                                              input logic [AWIDTH-1:0] word,
                                              input logic [AWIDTH-1:0] sdat);
    logic [AWIDTH-1:0] w;
    w = word;
    if (op == OP_SB) w[{lane, 3'b000} +: 8] = sdat[7:0];
    else             w[{lane[1], 4'b0000} +: 16] = sdat[15:0];
    return w;
  endfunction

  // Decode the incoming request and its error conditions.
  always_comb begin
    req_op  = op_e'(ReqOp);
    req_idx = ReqAddr >> 2;
    req_err = (req_idx >= AWIDTH'(ALENGTH)) ||
              (((req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH)) && ReqAddr[0]) ||
              (((req_op == OP_LW) || (req_op == OP_SW)) && (ReqAddr[1:0] != 2'b00));
  end

  // Request/response FSM with registered memory and response outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_LW;
      lane_q     <= '0;
      wdat_q     <= '0;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      mem_wdat_q <= '0;
      resp_val_q <= 1'b0;
      resp_dat_q <= '0;
      resp_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ReqVal) begin
            op_q   <= req_op;
            lane_q <= ReqAddr[1:0];
            wdat_q <= ReqDat;
            if (req_err) begin
              resp_val_q <= 1'b1;
              resp_err_q <= 1'b1;
              resp_dat_q <= '0;
              state_q    <= S_RESP;
            end else begin
              mem_addr_q <= req_idx;
              resp_err_q <= 1'b0;
              if (req_op == OP_SW) begin
                mem_we_q   <= 1'b1;
                mem_wdat_q <= ReqDat;
                state_q    <= S_WR;
              end else begin
                state_q <= S_RD;
              end
            end
          end
        end
        S_RD: begin
          if (is_store(op_q)) begin
            mem_wdat_q <= merge(op_q, lane_q, MemReaDat, wdat_q);
            mem_we_q   <= 1'b1;
            state_q    <= S_WR;
          end else begin
            resp_dat_q <= load_ext(op_q, lane_q, MemReaDat);
            resp_val_q <= 1'b1;
            state_q    <= S_RESP;
          end
        end
        S_WR: begin
          mem_we_q   <= 1'b0;
          resp_dat_q <= '0;
          resp_val_q <= 1'b1;
          state_q    <= S_RESP;
        end
        S_RESP: begin
          if (RespRdy) begin
            resp_val_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ReqRdy    = (state_q == S_IDLE);
  assign RespVal   = resp_val_q;
  assign RespDat   = resp_dat_q;
  assign RespErr   = resp_err_q;
  assign MemAddr   = mem_addr_q;
  assign MemWE     = mem_we_q;
  assign MemWriDat = mem_wdat_q;

`ifdef LSU_STATS_EN
  logic [15:0] ld_cnt_q, st_cnt_q, err_cnt_q;
  logic        resp_fire;

  assign resp_fire = (state_q == S_RESP) && RespRdy;

  // Saturating per-class counters, stepped when a response is accepted.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ld_cnt_q  <= '0;
      st_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (resp_fire) begin
      if (resp_err_q) begin
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 16'd1;
      end else if (is_store(op_q)) begin
        if (st_cnt_q != '1) st_cnt_q <= st_cnt_q + 16'd1;
      end else begin
        if (ld_cnt_q != '1) ld_cnt_q <= ld_cnt_q + 16'd1;
      end
    end
  end

  assign LdCnt  = ld_cnt_q;
  assign StCnt  = st_cnt_q;
  assign ErrCnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_lsu_subword_rmw.sv
// Self-checking bench for lsu_subword_rmw with a Datmem model and a reference model.
module tb_lsu_subword_rmw;
  localparam int AL = 128;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        ReqVal = 1'b0;
  logic        ReqRdy;
  logic [2:0]  ReqOp = '0;
  logic [31:0] ReqAddr = '0;
  logic [31:0] ReqDat = '0;
  logic        RespVal;
  logic        RespRdy = 1'b0;
  logic [31:0] RespDat;
  logic        RespErr;
  logic [31:0] MemAddr;
  logic        MemWE;
  logic [31:0] MemWriDat;
  logic [31:0] MemReaDat;
`ifdef LSU_STATS_EN
  logic [15:0] LdCnt, StCnt, ErrCnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [0:AL-1];
  logic [31:0] ref_mem [0:AL-1];

  lsu_subword_rmw #(.AWIDTH(32), .ALENGTH(AL)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ReqVal(ReqVal), .ReqRdy(ReqRdy), .ReqOp(ReqOp),
    .ReqAddr(ReqAddr), .ReqDat(ReqDat), .RespVal(RespVal), .RespRdy(RespRdy),
    .RespDat(RespDat), .RespErr(RespErr), .MemAddr(MemAddr), .MemWE(MemWE),
    .MemWriDat(MemWriDat), .MemReaDat(MemReaDat)
`ifdef LSU_STATS_EN
    , .LdCnt(LdCnt), .StCnt(StCnt), .ErrCnt(ErrCnt)
`endif
  );

  always #5 Clk = ~Clk;

  // Datmem: word 0 hardwired to zero, combinational read.
  assign MemReaDat = (MemAddr != 0 && MemAddr < AL) ? mem[MemAddr[6:0]] : 32'h0;
  always @(posedge Clk)
    if (MemWE && MemAddr != 0 && MemAddr < AL) mem[MemAddr[6:0]] <= MemWriDat;

  task automatic set_word(input int idx, input logic [31:0] val);
    mem[idx]     = val;
    ref_mem[idx] = val;
  endtask

  // Reference behaviour from the op/address rules, using plain arithmetic.
  task automatic ref_exec(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] dat,
                          output logic [31:0] edat, output logic eerr,
                          output int elat, output int ewe);
    logic [31:0] idx, w, part, nw;
    int sh, hsh;
    idx  = addr / 4;
    sh   = int'(addr % 4) * 8;
    hsh  = int'((addr % 4) / 2) * 16;
    eerr = (idx >= AL) ||
           ((op == 1 || op == 2 || op == 6) && (addr % 2 != 0)) ||
           ((op == 0 || op == 5) && (addr % 4 != 0));
    edat = 0;
    ewe  = 0;
    elat = 1;
    if (!eerr) begin
      w = (idx == 0) ? 32'h0 : ref_mem[idx];
      if (op <= 4) begin
        elat = 2;
        if (op == 0) edat = w;
        else if (op == 1 || op == 2) begin
          part = (w >> hsh) % 65536;
          edat = (op == 1 && part >= 32768) ? part + 32'hFFFF_0000 : part;
        end else begin
          part = (w >> sh) % 256;
          edat = (op == 3 && part >= 128) ? part + 32'hFFFF_FF00 : part;
        end
      end else begin
        ewe = 1;
        if (op == 5) begin
          nw = dat;
          elat = 2;
        end else if (op == 6) begin
          nw = (w & ~(32'hFFFF << hsh)) | ((dat % 65536) << hsh);
          elat = 3;
        end else begin
          nw = (w & ~(32'hFF << sh)) | ((dat % 256) << sh);
          elat = 3;
        end
        if (idx != 0) ref_mem[idx] = nw;
      end
    end
  endtask

  // Issue one request and wait (bounded) for RespVal; the response is left pending.
  task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] dat,
                         output logic [31:0] rdat, output logic rerr, output int lat,
                         output int wes, output logic [31:0] wdat);
    int n;
    n = 0;
    rdat = 'x; rerr = 'x; lat = -1; wes = -1; wdat = 'x;
    while (!ReqRdy && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (!ReqRdy) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout: ReqRdy=%b required 1", ReqRdy);
      return;
    end
    @(negedge Clk);
    ReqVal = 1'b1; ReqOp = op; ReqAddr = addr; ReqDat = dat;
    @(posedge Clk); #1;
    ReqVal = 1'b0;
    lat = 1; wes = 0; wdat = '0;
    while (!RespVal && lat < 20) begin
      if (MemWE) begin
        wes++;
        wdat = MemWriDat;
      end
      @(posedge Clk); #1;
      lat++;
    end
    if (!RespVal) begin
      checks++; errors++;
      $display("FAIL resp_timeout: RespVal=%b required 1 (op %0d addr %h)", RespVal, op, addr);
      lat = -1;
      return;
    end
    rdat = RespDat;
    rerr = RespErr;
  endtask

  task automatic accept_resp();
    @(negedge Clk);
    RespRdy = 1'b1;
    @(posedge Clk); #1;
    RespRdy = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (MemWE !== 1'b0 || RespVal !== 1'b0 || RespErr !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: MemWE=%b RespVal=%b RespErr=%b required 0 0 0", MemWE, RespVal, RespErr);
    end
    checks++;
    if (MemAddr !== 32'h0 || MemWriDat !== 32'h0 || RespDat !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: MemAddr=%h MemWriDat=%h RespDat=%h required 0", MemAddr, MemWriDat, RespDat);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    checks++;
    if (ReqRdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy: ReqRdy=%b required 1", ReqRdy);
    end
  endtask

  task automatic test_load_ext();
    logic [31:0] d, wd; logic e; int lat, wes;
    logic [31:0] addrs [3];
    logic [2:0]  ops   [3];
    logic [31:0] exps  [3];
    addrs = '{32'h0C, 32'h0D, 32'h0E};
    ops   = '{3'd3, 3'd4, 3'd1};
    exps  = '{32'hFFFF_FFA1, 32'h0000_00F0, 32'hFFFF_8070};
    set_word(3, 32'h8070_F0A1);
    for (int i = 0; i < 3; i++) begin
      run_req(ops[i], addrs[i], 32'h0, d, e, lat, wes, wd);
      checks++;
      if (d !== exps[i] || e !== 1'b0) begin
        errors++;
        $display("FAIL load_ext_%0d: RespDat=%h RespErr=%b required %h 0", i, d, e, exps[i]);
      end
      checks++;
      if (lat != 2 || wes != 0) begin
        errors++;
        $display("FAIL load_ext_lat_%0d: latency=%0d writes=%0d required 2 0", i, lat, wes);
      end
      accept_resp();
    end
  endtask

  task automatic test_sb_rmw();
    logic [31:0] d, wd; logic e; int lat, wes;
    set_word(5, 32'h1122_3344);
    run_req(3'd7, 32'h16, 32'h0000_00AB, d, e, lat, wes, wd);
    checks++;
    if (wes != 1 || wd !== 32'h11AB_3344) begin
      errors++;
      $display("FAIL sb_write: writes=%0d MemWriDat=%h required 1 11ab3344", wes, wd);
    end
    checks++;
    if (lat != 3 || e !== 1'b0 || d !== 32'h0) begin
      errors++;
      $display("FAIL sb_resp: latency=%0d RespErr=%b RespDat=%h required 3 0 0", lat, e, d);
    end
    accept_resp();
    ref_mem[5] = 32'h11AB_3344;
    run_req(3'd0, 32'h14, 32'h0, d, e, lat, wes, wd);
    checks++;
    if (d !== 32'h11AB_3344) begin
      errors++;
      $display("FAIL sb_readback: RespDat=%h required 11ab3344", d);
    end
    accept_resp();
  endtask

  task automatic test_errors();
    logic [31:0] d, wd; logic e; int lat, wes;
    logic [2:0]  ops   [3];
    logic [31:0] addrs [3];
    ops   = '{3'd0, 3'd6, 3'd5};
    addrs = '{32'h02, 32'h05, 32'h200};
    for (int i = 0; i < 3; i++) begin
      run_req(ops[i], addrs[i], 32'hDEAD_BEEF, d, e, lat, wes, wd);
      checks++;
      if (e !== 1'b1 || d !== 32'h0 || lat != 1 || wes != 0) begin
        errors++;
        $display("FAIL error_%0d: RespErr=%b RespDat=%h latency=%0d writes=%0d required 1 0 1 0",
                 i, e, d, lat, wes);
      end
      accept_resp();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d, wd; logic e; int lat, wes;
    set_word(9, 32'hCAFE_F00D);
    run_req(3'd0, 32'h24, 32'h0, d, e, lat, wes, wd);
    checks++;
    if (d !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL bp_data: RespDat=%h required cafef00d", d);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      checks++;
      if (RespVal !== 1'b1 || RespDat !== 32'hCAFE_F00D || RespErr !== 1'b0 || ReqRdy !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: RespVal=%b RespDat=%h RespErr=%b ReqRdy=%b required 1 cafef00d 0 0",
                 i, RespVal, RespDat, RespErr, ReqRdy);
      end
    end
    accept_resp();
    checks++;
    if (ReqRdy !== 1'b1 || RespVal !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: ReqRdy=%b RespVal=%b required 1 0", ReqRdy, RespVal);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, wd, addr, dat, ed; logic e, ee; int lat, wes, el, ew;
    logic [2:0] op;
    for (int i = 0; i < 60; i++) begin
      op   = 3'($urandom_range(0, 7));
      addr = $urandom_range(0, 32'h21F);
      if ($urandom_range(0, 2) != 0) addr = addr & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) addr = addr + (op == 6 ? 32'd2 : 32'd1);
      dat  = $urandom;
      ref_exec(op, addr, dat, ed, ee, el, ew);
      run_req(op, addr, dat, d, e, lat, wes, wd);
      checks++;
      if (d !== ed || e !== ee) begin
        errors++;
        $display("FAIL rand_resp_%0d: op %0d addr %h RespDat=%h RespErr=%b required %h %b",
                 i, op, addr, d, e, ed, ee);
      end
      checks++;
      if (lat != el || wes != ew) begin
        errors++;
        $display("FAIL rand_timing_%0d: op %0d addr %h latency=%0d writes=%0d required %0d %0d",
                 i, op, addr, lat, wes, el, ew);
      end
      accept_resp();
    end
    // Sweep every word to confirm memory contents match the model.
    for (int w = 0; w < AL; w++) begin
      run_req(3'd0, 32'(w * 4), 32'h0, d, e, lat, wes, wd);
      checks++;
      if (d !== ((w == 0) ? 32'h0 : ref_mem[w])) begin
        errors++;
        $display("FAIL rand_sweep_%0d: RespDat=%h required %h", w, d, (w == 0) ? 32'h0 : ref_mem[w]);
      end
      accept_resp();
    end
  endtask

  task automatic test_reset_mid_wr();
    logic [31:0] d, wd; logic e; int lat, wes;
    set_word(7, 32'h5566_7788);
    @(negedge Clk);
    ReqVal = 1'b1; ReqOp = 3'd6; ReqAddr = 32'h1E; ReqDat = 32'h0000_BEEF;
    @(posedge Clk); #1;
    ReqVal = 1'b0;
    @(posedge Clk); #1;
    checks++;
    if (MemWE !== 1'b1) begin
      errors++;
      $display("FAIL rst_wr_entry: MemWE=%b required 1", MemWE);
    end
    Rst_n = 1'b0;
    #1;
    checks++;
    if (MemWE !== 1'b0 || RespVal !== 1'b0 || ReqRdy !== 1'b1) begin
      errors++;
      $display("FAIL rst_wr_async: MemWE=%b RespVal=%b ReqRdy=%b required 0 0 1", MemWE, RespVal, ReqRdy);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
`ifdef LSU_STATS_EN
    checks++;
    if (LdCnt !== 16'd0 || StCnt !== 16'd0 || ErrCnt !== 16'd0) begin
      errors++;
      $display("FAIL stats_reset: Ld=%0d St=%0d Err=%0d required 0 0 0", LdCnt, StCnt, ErrCnt);
    end
`endif
    run_req(3'd0, 32'h1C, 32'h0, d, e, lat, wes, wd);
    checks++;
    if (d !== 32'h5566_7788 || e !== 1'b0) begin
      errors++;
      $display("FAIL rst_wr_nowrite: RespDat=%h RespErr=%b required 55667788 0", d, e);
    end
    accept_resp();
`ifdef LSU_STATS_EN
    run_req(3'd4, 32'h1D, 32'h0, d, e, lat, wes, wd);  accept_resp();
    run_req(3'd2, 32'h1E, 32'h0, d, e, lat, wes, wd);  accept_resp();
    run_req(3'd5, 32'h40, 32'h1, d, e, lat, wes, wd);  accept_resp();
    run_req(3'd7, 32'h41, 32'h2, d, e, lat, wes, wd);  accept_resp();
    run_req(3'd1, 32'h43, 32'h0, d, e, lat, wes, wd);  accept_resp();
    checks++;
    if (LdCnt !== 16'd3 || StCnt !== 16'd2 || ErrCnt !== 16'd1) begin
      errors++;
      $display("FAIL stats_count: Ld=%0d St=%0d Err=%0d required 3 2 1", LdCnt, StCnt, ErrCnt);
    end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < AL; i++) set_word(i, (i == 0) ? 32'h0 : $urandom);
    repeat (2) @(negedge Clk);
    test_reset();
    test_load_ext();
    test_sb_rmw();
    test_errors();
    test_backpressure();
    test_random();
    test_reset_mid_wr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
